// File: rtl/uart_periph_pkg.sv
// Shared definitions for the UART transmit peripheral: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_periph_pkg;

   // Word offsets (daddr[3:2]) within the 16-byte register window
   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_BAUDDIV = 2'd2;

   // STATUS register bit positions
   localparam int STAT_BUSY   = 0;
   localparam int STAT_FULL   = 1;
   localparam int STAT_EMPTY  = 2;
   localparam int STAT_OVF    = 3;
   localparam int STAT_CNT_LO = 4;
   localparam int STAT_CNT_HI = 8;
   localparam int STAT_PARITY = 9;

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_PRESENT = 1'b1;
`else
   localparam logic PARITY_PRESENT = 1'b0;
`endif

   // Transmit FSM states; the PARITY state only exists in parity builds
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_t;

   // Even parity: the bit that makes the total number of ones even
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO feeding the UART transmitter. Pointers wrap modulo DEPTH
// (DEPTH must be a power of two); count runs 0..DEPTH. The head byte is
// available combinationally so the FSM can load it on the popping edge.
module uart_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic                           pop,
   input  logic [7:0]                     wdata,
   output logic [7:0]                     rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // Storage write; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   // Pointer and occupancy tracking; caller guarantees push only when it fits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem[rd_ptr_reg];
   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV registers, a byte
// FIFO and a registered serial output (8 data bits, LSB first, 1 stop bit).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit and sets STATUS bit 9.
module uart_tx_periph
   import uart_periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic        tx,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // Bus decode
   logic       sel;
   logic [1:0] off;
   logic       push_req;
   logic       push_ok;
   logic       drop;
   logic       ovf_clr;
   logic       div_wr;
   logic [15:0] div_new;

   // FIFO interface
   logic          pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [4:0]    cnt5;

   // Registers and FSM state
   logic        overflow_reg;
   logic [15:0] baud_div_reg;
   tx_state_t   state_reg;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_idx_reg;
   logic [15:0] baud_cnt_reg;
   logic [15:0] bit_div_reg;
   logic        tx_reg;
   logic        bit_end;
`ifdef UART_TX_PARITY_EN
   logic        parity_reg;
`endif

   // Bus bits with no register behind them
   logic unused_bits;
   assign unused_bits = ^{dwdata[31:16], daddr[1:0], dwe[3:2]};

   assign sel = (daddr[31:4] == BASE_ADDR[31:4]);
   assign off = daddr[3:2];

   // A pop frees a slot on the same edge, so a push into a full FIFO still fits
   assign pop      = (state_reg == ST_IDLE) && !fifo_empty;
   assign push_req = sel && (off == OFF_TXDATA) && dwe[0];
   assign push_ok  = push_req && (!fifo_full || pop);
   assign drop     = push_req && fifo_full && !pop;
   assign ovf_clr  = sel && (off == OFF_STATUS) && dwe[0] && dwdata[STAT_OVF];

   assign div_wr  = sel && (off == OFF_BAUDDIV) && (dwe[1] || dwe[0]);
   assign div_new = {dwe[1] ? dwdata[15:8] : baud_div_reg[15:8],
                     dwe[0] ? dwdata[7:0]  : baud_div_reg[7:0]};

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .wdata (dwdata[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cnt5 = 5'(fifo_count);

   // Sticky overflow (a drop beats a clear) and the baud divisor register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_reg <= 1'b0;
         baud_div_reg <= DIV_RESET;
      end else begin
         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (ovf_clr) begin
            overflow_reg <= 1'b0;
         end
         if (div_wr) begin
            baud_div_reg <= (div_new == 16'd0) ? 16'd1 : div_new;
         end
      end
   end

   // The divisor is latched per bit, so a BAUDDIV write only affects later bits
   assign bit_end = (baud_cnt_reg == bit_div_reg - 16'd1);

   // Transmit FSM with registered serial output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         baud_cnt_reg <= '0;
         bit_div_reg  <= DIV_RESET;
         tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else if (state_reg == ST_IDLE) begin
         if (pop) begin
            shift_reg    <= fifo_rdata;
            bit_idx_reg  <= '0;
            baud_cnt_reg <= '0;
            bit_div_reg  <= baud_div_reg;
            tx_reg       <= 1'b0;
            state_reg    <= ST_START;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= even_parity(fifo_rdata);
`endif
         end
      end else if (!bit_end) begin
         baud_cnt_reg <= baud_cnt_reg + 16'd1;
      end else begin
         baud_cnt_reg <= '0;
         bit_div_reg  <= baud_div_reg;
         case (state_reg)
            ST_START: begin
               tx_reg      <= shift_reg[0];
               shift_reg   <= {1'b0, shift_reg[7:1]};
               bit_idx_reg <= '0;
               state_reg   <= ST_DATA;
            end
            ST_DATA: begin
               if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_reg    <= parity_reg;
                  state_reg <= ST_PARITY;
`else
                  tx_reg    <= 1'b1;
                  state_reg <= ST_STOP;
`endif
               end else begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= {1'b0, shift_reg[7:1]};
                  bit_idx_reg <= bit_idx_reg + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               tx_reg    <= 1'b1;
               state_reg <= ST_STOP;
            end
`endif
            ST_STOP: begin
               tx_reg    <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               tx_reg    <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational read mux; no side effects on read
   always_comb begin
      drdata = 32'd0;
      if (sel) begin
         case (off)
            OFF_STATUS: begin
               drdata[STAT_BUSY]                 = (state_reg != ST_IDLE);
               drdata[STAT_FULL]                 = fifo_full;
               drdata[STAT_EMPTY]                = fifo_empty;
               drdata[STAT_OVF]                  = overflow_reg;
               drdata[STAT_CNT_HI:STAT_CNT_LO]   = cnt5;
               drdata[STAT_PARITY]               = PARITY_PRESENT;
            end
            OFF_BAUDDIV: drdata[15:0] = baud_div_reg;
            default:     drdata = 32'd0;
         endcase
      end
   end

   assign tx  = tx_reg;
   assign irq = fifo_empty && (state_reg == ST_IDLE);

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000: register window base, 16-byte aligned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, 2 to 16.
REQ-003 SHALL have parameter DIV_RESET, default 16'd434: BAUDDIV value after reset.
REQ-004 SHALL have ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- daddr  input  32  data-bus byte address from the CPU.
- dwdata  input  32  data-bus write data.
- dwe  input  4  per-byte write enables; 0 means read or no access.
- drdata  output  32  read data returned to the CPU.
- tx  output  1  serial line, idle high.
- irq  output  1  high while the FIFO is empty and the FSM is IDLE.

Function
REQ-005 SHALL select when daddr[31:4]==BASE_ADDR[31:4]; offset is daddr[3:2].
REQ-006 SHALL define the register map:
- 0x0 TXDATA: write only; reads as 0.
- 0x4 STATUS: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] count.
- 0x8 BAUDDIV: bits[15:0].
- 0xC: reserved; reads 0, ignores writes.
REQ-007 drdata SHALL be combinational from daddr, with no read side effects; it SHALL be 0 when not selected.
REQ-008 A selected TXDATA write with dwe[0]=1 SHALL push dwdata[7:0].
- The push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- Otherwise the write is dropped and overflow is set.
REQ-009 A selected STATUS write with dwe[0]=1 and dwdata[3]=1 SHALL clear overflow. If a drop occurs in the same cycle, set wins.
REQ-010 BAUDDIV writes SHALL honour dwe[1:0] per byte. A resulting value of 0 SHALL be stored as 1.
REQ-011 The TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- Each bit time lasts BAUDDIV clk cycles.
- A BAUDDIV change takes effect at the next bit boundary.
REQ-012 IDLE with a non-empty FIFO SHALL pop the head byte on that edge and enter START. tx SHALL go low on the following cycle.
REQ-013 DATA SHALL shift 8 bits LSB first. STOP SHALL drive tx high for one bit time, then return to IDLE.
- Back-to-back frames are therefore separated by exactly one idle clk cycle.
REQ-014 Without parity (REQ-019), DATA SHALL go directly to STOP.
REQ-015 tx SHALL be registered (no combinational path from bus to tx).
REQ-016 The FIFO pointers SHALL wrap modulo FIFO_DEPTH. count SHALL range 0..FIFO_DEPTH.

Reset
REQ-017 While reset=0, regardless of the current state:
- tx=1, irq=1, FSM=IDLE, FIFO empty, overflow=0, BAUDDIV=DIV_RESET, bit counters=0.
- A frame in progress is abandoned.
REQ-018 drdata SHALL reflect the reset register values while in reset.

Configuration
REQ-019 When macro UART_TX_PARITY_EN is defined:
- the PARITY state SHALL send one even-parity bit (XOR of the 8 data bits) between DATA and STOP;
- STATUS bit9 SHALL read 1.
REQ-020 When UART_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and STATUS bit9 SHALL read 0.

Structure
REQ-021 Package uart_periph_pkg SHALL hold:
- the register offsets (OFF_TXDATA, OFF_STATUS, OFF_BAUDDIV);
- the STATUS bit indices;
- the FSM state enum.
REQ-022 The FIFO SHALL be sub-module uart_tx_fifo, with push/pop/full/empty/count, parameterised by FIFO_DEPTH.

Verification
REQ-023 Reset released, BAUDDIV=4. Write 0x55 to 0x1000 ->
- tx low for 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles;
- STATUS busy=1 during the frame, irq=1 after it.
REQ-024 With the FSM busy and FIFO_DEPTH=4, write 5 bytes ->
- the 5th byte is dropped, STATUS reads full=1, overflow=1, count=4;
- a STATUS write of 0x8 clears overflow.
REQ-025 Write 0x0000 to BAUDDIV with dwe=4'b0011 -> reads back 1; each tx bit lasts 1 cycle.
REQ-026 Write 0xA1, 0xB2 back to back -> two frames separated by exactly one idle cycle, in order 0xA1 then 0xB2.
REQ-027 Assert reset=0 mid-DATA -> tx=1 immediately (asynchronous), STATUS reads 0x4, subsequent writes transmit normally.
REQ-028 With UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 precedes STOP; a read of 0x100C returns 0.
